axis_rx_absorb: RTL and testbench

Receive-side companion to the TREADY-ignoring stream sources in this design, such as the 100G Ethernet RX core.
- Accepts every input beat unconditionally and stores it in a packet-commit circular buffer.
- A packet becomes visible on the output only after its TLAST beat is stored. Packets that do not fit, or that end with an error flag, are discarded whole.
- Sits between the MAC RX stream and the RDMA receive logic, and reports drop and error events.

---
 rtl/axis_rx_absorb_pkg.sv | 22 ++
 rtl/axis_rx_absorb_ram.sv | 23 ++
 rtl/axis_rx_absorb.sv | 148 ++++++++++++++
 tb/tb_axis_rx_absorb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rx_absorb_pkg.sv
// Shared types and sizing helpers for the receive-side absorbing buffer.
package axis_rx_absorb_pkg;

  // Input-side state: SYNC skips a partially seen packet after reset,
  // DROP discards the remainder of a packet that overflowed.
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACCEPT = 2'd1,
    DROP   = 2'd2
  } state_t;

  // Pointer width: one extra MSB so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Stored entry: {TDATA, TUSER, TKEEP, TLAST}.
  function automatic int entry_width(input int data_w, input int user_w);
    return data_w + user_w + data_w / 8 + 1;
  endfunction

endpackage

// File: rtl/axis_rx_absorb_ram.sv
// Simple dual-port beat store: synchronous write, combinational read.
module axis_rx_absorb_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are not reset, pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_rx_absorb.sv
// Packet-commit receive buffer for sources that ignore TREADY. Every beat
// is accepted; a packet is exposed downstream only once its TLAST beat is
// stored. Packets that overflow or end with a bad-frame flag are dropped.
module axis_rx_absorb
  import axis_rx_absorb_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 1,
  parameter int DEPTH       = 64,
  parameter int FILTER_ERR  = 1,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TDATA_WIDTH-1:0]   AXIS_IN_TDATA,
  input  logic [TUSER_WIDTH-1:0]   AXIS_IN_TUSER,
  input  logic [TDATA_WIDTH/8-1:0] AXIS_IN_TKEEP,
  input  logic                     AXIS_IN_TLAST,
  input  logic                     AXIS_IN_TVALID,
  output logic                     AXIS_IN_TREADY,
  output logic [TDATA_WIDTH-1:0]   AXIS_OUT_TDATA,
  output logic [TUSER_WIDTH-1:0]   AXIS_OUT_TUSER,
  output logic [TDATA_WIDTH/8-1:0] AXIS_OUT_TKEEP,
  output logic                     AXIS_OUT_TLAST,
  output logic                     AXIS_OUT_TVALID,
  input  logic                     AXIS_OUT_TREADY,
  output logic                     overrun,
  output logic [CNT_WIDTH-1:0]     pkt_count,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [CNT_WIDTH-1:0]     err_count
);

  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int AW      = PTR_W - 1;
  localparam int KEEP_W  = TDATA_WIDTH / 8;
  localparam int ENTRY_W = entry_width(TDATA_WIDTH, TUSER_WIDTH);

  state_t           state;
  logic [PTR_W-1:0] wr_ptr, cmt_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_nxt, occ;
  logic             full, bad, wr_en, load;

  logic [ENTRY_W-1:0]     wdata, rdata;
  logic [TDATA_WIDTH-1:0] r_data;
  logic [TUSER_WIDTH-1:0] r_user;
  logic [KEEP_W-1:0]      r_keep;
  logic                   r_last;

  assign AXIS_IN_TREADY = 1'b1;

  // Occupancy uses the registered rd_ptr, so a same-cycle read never
  // makes room for a same-cycle write.
  assign occ    = wr_ptr - rd_ptr;
  assign full   = (occ == PTR_W'(DEPTH));
  assign wr_nxt = wr_ptr + PTR_W'(1);
  assign bad    = (FILTER_ERR != 0) && AXIS_IN_TUSER[0];
  assign wr_en  = (state == ACCEPT) && AXIS_IN_TVALID && !full;
  assign wdata  = {AXIS_IN_TDATA, AXIS_IN_TUSER, AXIS_IN_TKEEP, AXIS_IN_TLAST};

  axis_rx_absorb_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign {r_data, r_user, r_keep, r_last} = rdata;

  // Input FSM: store beats, commit on good TLAST, roll back on error/overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      wr_ptr     <= '0;
      cmt_ptr    <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
      err_count  <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (AXIS_IN_TVALID) begin
        case (state)
          SYNC: begin
            if (AXIS_IN_TLAST) state <= ACCEPT;
          end
          ACCEPT: begin
            if (!full) begin
              if (AXIS_IN_TLAST && bad) begin
                wr_ptr    <= cmt_ptr;
                err_count <= err_count + CNT_WIDTH'(1);
              end else if (AXIS_IN_TLAST) begin
                wr_ptr    <= wr_nxt;
                cmt_ptr   <= wr_nxt;
                pkt_count <= pkt_count + CNT_WIDTH'(1);
              end else begin
                wr_ptr <= wr_nxt;
              end
            end else begin
              // No room: drop the whole packet once, skip its remainder.
              wr_ptr     <= cmt_ptr;
              drop_count <= drop_count + CNT_WIDTH'(1);
              overrun    <= 1'b1;
              if (!AXIS_IN_TLAST) state <= DROP;
            end
          end
          DROP: begin
            if (AXIS_IN_TLAST) state <= ACCEPT;
          end
          default: state <= SYNC;
        endcase
      end else if (state == SYNC) begin
        // An idle cycle means we are between packets.
        state <= ACCEPT;
      end
    end
  end

  // Output register: load the next committed beat whenever the stage is
  // empty or being drained; hold steady under back-pressure.
  assign load = (rd_ptr != cmt_ptr) && (!AXIS_OUT_TVALID || AXIS_OUT_TREADY);

  // Output stage and read pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr          <= '0;
      AXIS_OUT_TVALID <= 1'b0;
      AXIS_OUT_TDATA  <= '0;
      AXIS_OUT_TUSER  <= '0;
      AXIS_OUT_TKEEP  <= '0;
      AXIS_OUT_TLAST  <= 1'b0;
    end else if (load) begin
      rd_ptr          <= rd_ptr + PTR_W'(1);
      AXIS_OUT_TVALID <= 1'b1;
      AXIS_OUT_TDATA  <= r_data;
      AXIS_OUT_TUSER  <= r_user;
      AXIS_OUT_TKEEP  <= r_keep;
      AXIS_OUT_TLAST  <= r_last;
    end else if (AXIS_OUT_TREADY) begin
      AXIS_OUT_TVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rx_absorb.sv
// Directed bench for axis_rx_absorb: latency, reset resync, overflow,
// error filtering and sustained back-to-back traffic with pointer wrap.
module tb_axis_rx_absorb;

  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [0:0]    in_user = '0;
  logic [KW-1:0] in_keep = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [0:0]    out_user;
  logic [KW-1:0] out_keep;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overrun;
  logic [31:0]   pkt_count, drop_count, err_count;

  axis_rx_absorb #(
    .TDATA_WIDTH (DW),
    .TUSER_WIDTH (1),
    .DEPTH       (64),
    .FILTER_ERR  (1),
    .CNT_WIDTH   (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .AXIS_IN_TDATA   (in_data),
    .AXIS_IN_TUSER   (in_user),
    .AXIS_IN_TKEEP   (in_keep),
    .AXIS_IN_TLAST   (in_last),
    .AXIS_IN_TVALID  (in_valid),
    .AXIS_IN_TREADY  (in_ready),
    .AXIS_OUT_TDATA  (out_data),
    .AXIS_OUT_TUSER  (out_user),
    .AXIS_OUT_TKEEP  (out_keep),
    .AXIS_OUT_TLAST  (out_last),
    .AXIS_OUT_TVALID (out_valid),
    .AXIS_OUT_TREADY (out_ready),
    .overrun         (overrun),
    .pkt_count       (pkt_count),
    .drop_count      (drop_count),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  beat_t rxq[$];
  int    ovr_pulses = 0;
  int    n_assert = 0;
  int    n_fail = 0;
  int    ovr_beat;

  // Gap tracking: committed-but-undelivered beats must keep TVALID high.
  logic gap_en = 1'b0;
  int   cm_prev = 0, cm_cur = 0, recv = 0, gap_viol = 0;

  // Inputs change at posedge+1, so a negedge sample sees exactly what the
  // next posedge will act on.
  always @(negedge clk) begin
    if (out_valid && out_ready)
      rxq.push_back('{d: out_data, k: out_keep, l: out_last, u: out_user[0]});
    if (overrun) ovr_pulses++;
    if (!gap_en) begin
      cm_prev = 0; cm_cur = 0; recv = 0;
    end else begin
      if (cm_prev > recv && !out_valid) gap_viol++;
      if (out_valid && out_ready) recv++;
      cm_prev = cm_cur;
      if (in_valid && in_last) cm_cur++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send an n-beat packet, data = base+i; records the first beat whose
  // edge raised overrun (-1 if none).
  task automatic send_pkt(input int n, input logic [DW-1:0] base,
                          input logic bad, input logic [KW-1:0] last_keep);
    ovr_beat = -1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DW'(i);
      in_last  = (i == n - 1);
      in_user  = (i == n - 1) ? bad : 1'b0;
      in_keep  = (i == n - 1) ? last_keep : '1;
      tick();
      if (overrun && ovr_beat < 0) ovr_beat = i;
    end
    in_valid = 1'b0; in_last = 1'b0; in_user = '0;
  endtask

  task automatic reset_clean();
    in_valid = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();  // one idle cycle moves SYNC -> ACCEPT
  endtask

  initial begin
    int base, bad_cnt, ob;

    // ---- T1: reset state, 3-beat packet, latency ----
    reset = 1'b1;
    tick(); tick();
    chk("rst_tvalid", out_valid, 0);
    chk("rst_tready", in_ready, 1);
    chk("rst_overrun", overrun, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_err", err_count, 0);
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    base = rxq.size();
    send_pkt(3, 32'h100, 1'b0, 4'h3);
    chk("t1_lat_e0", out_valid, 0);       // after edge E (TLAST sampled)
    tick();
    chk("t1_lat_e1", out_valid, 1);       // after edge E+1
    chk("t1_first", out_data, 32'h100);
    repeat (4) tick();
    chk("t1_count", rxq.size() - base, 3);
    chk("t1_b0", rxq[base].d, 32'h100);
    chk("t1_b1", rxq[base+1].d, 32'h101);
    chk("t1_b2", rxq[base+2].d, 32'h102);
    chk("t1_b1_last", rxq[base+1].l, 0);
    chk("t1_b2_last", rxq[base+2].l, 1);
    chk("t1_b2_keep", rxq[base+2].k, 4'h3);
    chk("t1_pkt", pkt_count, 1);

    // ---- T2: reset released mid-packet ----
    base = rxq.size();
    in_valid = 1'b1; in_data = 32'hAA; in_last = 1'b0; in_keep = '1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();                               // beat AA discarded in SYNC
    in_data = 32'hAB; in_last = 1'b1;
    tick();                               // discarded TLAST -> ACCEPT
    send_pkt(4, 32'h200, 1'b0, 4'hF);
    repeat (8) tick();
    chk("t2_count", rxq.size() - base, 4);
    chk("t2_b0", rxq[base].d, 32'h200);
    chk("t2_b3", rxq[base+3].d, 32'h203);
    chk("t2_pkt", pkt_count, 1);

    // ---- T3: 60-beat packet fills, 8-beat packet overflows ----
    out_ready = 1'b0;
    reset_clean();
    base = rxq.size();
    ob = ovr_pulses;
    send_pkt(60, 32'h1000, 1'b0, 4'hF);
    send_pkt(8, 32'h2000, 1'b0, 4'hF);
    // The output register takes beat 0 of the first packet one edge after
    // its commit, freeing one slot: beats 1..5 of the second packet fit
    // (occupancy reaches 64), so the 6th beat (index 5) overflows.
    chk("t3_ovr_beat", ovr_beat, 5);
    repeat (3) tick();
    chk("t3_ovr_pulses", ovr_pulses - ob, 1);
    chk("t3_drop", drop_count, 1);
    chk("t3_pkt", pkt_count, 1);
    chk("t3_hold_valid", out_valid, 1);
    chk("t3_hold_data", out_data, 32'h1000);
    out_ready = 1'b1;
    repeat (70) tick();
    chk("t3_count", rxq.size() - base, 60);
    bad_cnt = 0;
    for (int i = 0; i < 60 && base + i < rxq.size(); i++)
      if (rxq[base+i].d !== 32'h1000 + i || rxq[base+i].l !== (i == 59)) bad_cnt++;
    chk("t3_order", bad_cnt, 0);

    // ---- T4: 65-beat packet into empty buffer ----
    reset_clean();
    base = rxq.size();
    ob = ovr_pulses;
    send_pkt(65, 32'h3000, 1'b0, 4'hF);
    chk("t4_ovr_beat", ovr_beat, 64);
    repeat (5) tick();
    chk("t4_no_out", rxq.size() - base, 0);
    chk("t4_drop", drop_count, 1);
    send_pkt(2, 32'h4000, 1'b0, 4'h1);
    repeat (5) tick();
    chk("t4_count", rxq.size() - base, 2);
    chk("t4_b0", rxq[base].d, 32'h4000);
    chk("t4_b1", rxq[base+1].d, 32'h4001);
    chk("t4_b1_keep", rxq[base+1].k, 4'h1);
    chk("t4_pkt", pkt_count, 1);
    chk("t4_ovr_pulses", ovr_pulses - ob, 1);

    // ---- T5: bad-frame packet filtered ----
    reset_clean();
    base = rxq.size();
    send_pkt(4, 32'h5000, 1'b1, 4'hF);
    send_pkt(2, 32'h6000, 1'b0, 4'hF);
    repeat (5) tick();
    chk("t5_err", err_count, 1);
    chk("t5_pkt", pkt_count, 1);
    chk("t5_drop", drop_count, 0);
    chk("t5_count", rxq.size() - base, 2);
    chk("t5_b0", rxq[base].d, 32'h6000);
    chk("t5_b0_user", rxq[base].u, 0);
    chk("t5_wr_ptr", dut.wr_ptr, 2);

    // ---- T6: 1-beat packets, 75% input, 50% ready, pointer wrap ----
    reset_clean();
    base = rxq.size();
    gap_en = 1'b1;
    begin
      int sent = 0;
      for (int i = 0; i < 200; i++) begin
        out_ready = i[0];
        if (i % 4 != 3) begin
          in_valid = 1'b1; in_last = 1'b1; in_user = '0; in_keep = '1;
          in_data = 32'h7000 + DW'(sent);
          sent++;
        end else begin
          in_valid = 1'b0; in_last = 1'b0;
        end
        tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && rxq.size() - base < sent; i++) tick();
      chk("t6_count", rxq.size() - base, sent);
      chk("t6_pkt", pkt_count, sent);
    end
    gap_en = 1'b0;
    chk("t6_drop", drop_count, 0);
    bad_cnt = 0;
    for (int i = 0; i < 150 && base + i < rxq.size(); i++)
      if (rxq[base+i].d !== 32'h7000 + i || rxq[base+i].l !== 1'b1) bad_cnt++;
    chk("t6_order", bad_cnt, 0);
    chk("t6_no_gap", gap_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
